pipe_stage_reg: RTL

Parametrised inter-stage pipeline register: the general successor to the fixed per-stage registers between EX, MEM and WB. It carries a control field and a data field, and adds a valid/ready handshake, stall back-pressure and synchronous flush. It gates control bits on bubbles so that write-enables never leak downstream. An optional skid slot registers the upstream ready path while keeping full throughput.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_slot.sv | 55 +++++
 rtl/pipe_stage_reg.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers (EX/MEM field layout, idle control, slot states).
package pipe_pkg;

  localparam int EXMEM_CTRL_W = 10;
  localparam int EXMEM_DATA_W = 96;

  // EX/MEM control field layout, MSB first: Regfile_we, DataMem_we, writeRegAddr[4:0], regSrc_mux[2:0]
  localparam int CTRL_REGFILE_WE_BIT = 9;
  localparam int CTRL_DATAMEM_WE_BIT = 8;
  localparam int CTRL_WADDR_MSB      = 7;
  localparam int CTRL_WADDR_LSB      = 3;
  localparam int CTRL_REGSRC_MSB     = 2;
  localparam int CTRL_REGSRC_LSB     = 0;

  localparam logic [EXMEM_CTRL_W-1:0] CTRL_IDLE_DEF = '0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid bit plus ctrl/data register with load, drop and kill controls.
module pipe_slot #(
  parameter int CTRL_W = 10,
  parameter int DATA_W = 96
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              drop,
  input  logic              kill,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              vld,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              vld_d, vld_q;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [DATA_W-1:0] data_d, data_q;

  // Kill only clears the valid bit; the payload stays stale and is masked downstream.
  always_comb begin
    vld_d  = vld_q;
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (load) begin
      vld_d  = 1'b1;
      ctrl_d = in_ctrl;
      data_d = in_data;
    end else if (drop) begin
      vld_d = 1'b0;
    end
    if (kill) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  assign vld  = vld_q;
  assign ctrl = ctrl_q;
  assign data = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, synchronous flush and bubble gating of ctrl.
// PIPE_SKID_EN adds a skid slot so in_ready comes from a flop; without it in_ready is combinational.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                CTRL_W    = EXMEM_CTRL_W,
  parameter int                DATA_W    = EXMEM_DATA_W,
  parameter logic [CTRL_W-1:0] CTRL_IDLE = CTRL_W'(CTRL_IDLE_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
);

  pipe_state_e       state_d, state_q;
  logic              accept;
  logic              fire;
  logic              main_load;
  logic              main_drop;
  logic              main_vld;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_in_ctrl;
  logic [DATA_W-1:0] main_in_data;

`ifdef PIPE_SKID_EN
  logic              skid_load;
  logic              skid_drop;
  logic              skid_vld;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              rdy_d, rdy_q;
`endif

  assign fire   = main_vld & out_ready;
  assign accept = in_valid & in_ready & ~flush;

  always_comb begin
    state_d      = state_q;
    main_load    = 1'b0;
    main_drop    = 1'b0;
    main_in_ctrl = in_ctrl;
    main_in_data = in_data;
`ifdef PIPE_SKID_EN
    skid_load    = 1'b0;
    skid_drop    = 1'b0;
`endif
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d   = BUSY;
          main_load = 1'b1;
        end
      end
      BUSY: begin
        if (accept && fire) begin
          main_load = 1'b1;
`ifdef PIPE_SKID_EN
        end else if (accept) begin
          state_d   = FULL;
          skid_load = 1'b1;
`endif
        end else if (fire) begin
          state_d   = EMPTY;
          main_drop = 1'b1;
        end
      end
`ifdef PIPE_SKID_EN
      FULL: begin
        // Skid drains into main; upstream stays blocked this cycle because in_ready is a flop.
        if (fire) begin
          state_d      = BUSY;
          main_load    = 1'b1;
          main_in_ctrl = skid_ctrl;
          main_in_data = skid_data;
          skid_drop    = 1'b1;
        end
      end
`endif
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .load    (main_load),
    .drop    (main_drop),
    .kill    (flush),
    .in_ctrl (main_in_ctrl),
    .in_data (main_in_data),
    .vld     (main_vld),
    .ctrl    (main_ctrl),
    .data    (main_data)
  );

`ifdef PIPE_SKID_EN
  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .drop    (skid_drop),
    .kill    (flush),
    .in_ctrl (in_ctrl),
    .in_data (in_data),
    .vld     (skid_vld),
    .ctrl    (skid_ctrl),
    .data    (skid_data)
  );

  // Ready is the registered complement of next-cycle skid occupancy; held low through reset.
  assign rdy_d = (state_d != FULL) & ~skid_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= rdy_d | (skid_vld & skid_drop);
    end
  end

  assign in_ready = rdy_q;
`else
  assign in_ready = ~rst & (out_ready | ~main_vld);
`endif

  assign out_valid = main_vld;
  assign out_ctrl  = main_vld ? main_ctrl : CTRL_IDLE;
  assign out_data  = main_data;

endmodule
